// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial link: state encodings and line levels.
// The receiving end of the link imports the same package.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_tx_baud_tick.sv
// Restartable bit-period counter; tick pulses on the last cycle of each bit period.
module baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// Parallel-in serial-out frame transmitter: start, DATA_W bits LSB first, stop.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              tx_out_q, tx_out_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic              tick;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(state_q == ST_IDLE),
        .tick (tick)
    );

    // Next state; outputs are derived from the next state so they register in step.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bit_d    = bit_q;
`ifdef SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    state_d  = ST_START;
                    shift_d  = tx_data;
`ifdef SERIAL_TX_PARITY_EN
                    parity_d = ^tx_data;
`endif
                end
            end
            ST_START: begin
                if (tick) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (tick) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        tx_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  tx_out_d = START_LEVEL;
            ST_DATA:   tx_out_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: tx_out_d = parity_d;
`endif
            default:   tx_out_d = IDLE_LEVEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_q      <= '0;
            tx_out_q   <= IDLE_LEVEL;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            tx_out_q   <= tx_out_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign tx_out   = tx_out_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;

endmodule
